// File: rtl/m3_pkg.sv
// m3_pkg: shared definitions for the 3-phase speed/power sequencer.
//   - m3_state_e : FSM state encoding (IDLE=0, RUN=1, REVERSE=2, FSTOP=3).
//   - M3_*       : default parameter values for the sequencer.
//   - M3_PERIOD_MAX_SIM : short slowest-period value for simulation builds.
package m3_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    REVERSE = 2'd2,
    FSTOP   = 2'd3
  } m3_state_e;

  localparam int M3_PERIOD_W       = 22;
  localparam int M3_PERIOD_MAX     = 4000000;
  localparam int M3_PERIOD_MAX_SIM = 400;
  localparam int M3_PERIOD_MIN     = 40;
  localparam int M3_STEPS          = 12;
  localparam int M3_STEP_W         = 4;
  localparam int M3_POWER_W        = 10;
  localparam int M3_POWER_MAX      = 1000;
  localparam int M3_POWER_INIT     = 100;
  localparam int M3_POWER_STEP     = 10;
  localparam int M3_RATE_SHIFT     = 5;

endpackage

// File: rtl/m3_sat_addsub.sv
// m3_sat_addsub: combinational saturating add/subtract.
//   valueI  : operand (unsigned, W bits)
//   deltaI  : amount to add or subtract (unsigned, W bits)
//   subI    : 1 = subtract, 0 = add
//   minI    : lower clamp
//   maxI    : upper clamp
//   resultO : value +/- delta clamped to [minI, maxI]
module m3_sat_addsub #(
  parameter int W = 8
) (
  input  logic [W-1:0] valueI,
  input  logic [W-1:0] deltaI,
  input  logic         subI,
  input  logic [W-1:0] minI,
  input  logic [W-1:0] maxI,
  output logic [W-1:0] resultO
);

  // Two guard bits: one for carry out of the add, one for the sign of a
  // subtraction that goes below zero.
  logic signed [W+1:0] valueS;
  logic signed [W+1:0] deltaS;
  logic signed [W+1:0] minS;
  logic signed [W+1:0] maxS;
  logic signed [W+1:0] rawS;

  assign valueS = $signed({2'b00, valueI});
  assign deltaS = $signed({2'b00, deltaI});
  assign minS   = $signed({2'b00, minI});
  assign maxS   = $signed({2'b00, maxI});

  always_comb begin
    rawS = subI ? (valueS - deltaS) : (valueS + deltaS);
    if (rawS > maxS) begin
      resultO = maxI;
    end else if (rawS < minS) begin
      resultO = minI;
    end else begin
      resultO = rawS[W-1:0];
    end
  end

endmodule

// File: rtl/m3_speed_power_sequencer.sv
// m3_speed_power_sequencer: commutation step timer with ramped period,
// power level management, force-stop and safe reversal by deceleration.
//   clkI, nRstI        : clock, asynchronous active-low reset
//   m3startI           : level, 1 = run, 0 = return to IDLE
//   m3forceStopI       : level, emergency stop (highest priority)
//   m3invRotateI       : requested direction (0 = forward)
//   m3freqINCi/DECi    : levels, speed up / slow down once per step boundary
//   m3powerINCi/DECi   : rising-edge power up / down
//   stepO, stepStbO    : step index and one-cycle strobe on change
//   periodO            : active step period in clocks
//   powerO             : power level (0 outside RUN/REVERSE)
//   dirO, runningO     : active direction, running indicator
//   stateO             : FSM state for debug
module m3_speed_power_sequencer
  import m3_pkg::*;
#(
  parameter int PERIOD_W   = M3_PERIOD_W,
  parameter int PERIOD_MAX = M3_PERIOD_MAX,
  parameter int PERIOD_MIN = M3_PERIOD_MIN,
  parameter int STEPS      = M3_STEPS,
  parameter int STEP_W     = M3_STEP_W,
  parameter int POWER_W    = M3_POWER_W,
  parameter int POWER_MAX  = M3_POWER_MAX,
  parameter int POWER_INIT = M3_POWER_INIT,
  parameter int POWER_STEP = M3_POWER_STEP,
  parameter int RATE_SHIFT = M3_RATE_SHIFT
) (
  input  logic                clkI,
  input  logic                nRstI,
  input  logic                m3startI,
  input  logic                m3forceStopI,
  input  logic                m3invRotateI,
  input  logic                m3freqINCi,
  input  logic                m3freqDECi,
  input  logic                m3powerINCi,
  input  logic                m3powerDECi,
  output logic [STEP_W-1:0]   stepO,
  output logic                stepStbO,
  output logic [PERIOD_W-1:0] periodO,
  output logic [POWER_W-1:0]  powerO,
  output logic                dirO,
  output logic                runningO,
  output logic [1:0]          stateO
);

  localparam logic [PERIOD_W-1:0] P_MAX     = PERIOD_W'(PERIOD_MAX);
  localparam logic [PERIOD_W-1:0] P_MIN     = PERIOD_W'(PERIOD_MIN);
  localparam logic [PERIOD_W-1:0] P_ONE     = PERIOD_W'(1);
  localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEPS - 1);
  localparam logic [STEP_W-1:0]   STEP_ONE  = STEP_W'(1);
  localparam logic [POWER_W-1:0]  PW_MAX    = POWER_W'(POWER_MAX);
  localparam logic [POWER_W-1:0]  PW_INIT   = POWER_W'(POWER_INIT);
  localparam logic [POWER_W-1:0]  PW_STEP   = POWER_W'(POWER_STEP);

  m3_state_e           state;
  logic [PERIOD_W-1:0] remain;
  logic [POWER_W-1:0]  power;
  logic                incQ;
  logic                decQ;

  logic                incEdge;
  logic                decEdge;
  logic                boundary;
  logic [PERIOD_W-1:0] periodShift;
  logic [PERIOD_W-1:0] periodDelta;
  logic                periodApply;
  logic                periodSub;
  logic [PERIOD_W-1:0] periodSat;
  logic [PERIOD_W-1:0] periodNext;
  logic                powerApply;
  logic [POWER_W-1:0]  powerSat;
  logic [POWER_W-1:0]  powerNext;
  logic [STEP_W-1:0]   stepNext;

  assign stateO = state;

  // Edge detectors run in every state so that an input already high at RUN
  // entry does not produce a spurious power step.
  assign incEdge = m3powerINCi & ~incQ;
  assign decEdge = m3powerDECi & ~decQ;

  assign boundary = (remain == P_ONE);

  // Ramp delta, never below one clock so the ramp always makes progress.
  assign periodShift = periodO >> RATE_SHIFT;
  assign periodDelta = (periodShift == '0) ? P_ONE : periodShift;

  // REVERSE ignores the frequency inputs and always decelerates.
  always_comb begin
    periodApply = 1'b0;
    periodSub   = 1'b0;
    if (state == REVERSE) begin
      periodApply = 1'b1;
    end else if (state == RUN) begin
      periodApply = m3freqINCi ^ m3freqDECi;
      periodSub   = m3freqINCi;
    end
  end

  m3_sat_addsub #(.W(PERIOD_W)) uPeriodSat (
    .valueI  (periodO),
    .deltaI  (periodDelta),
    .subI    (periodSub),
    .minI    (P_MIN),
    .maxI    (P_MAX),
    .resultO (periodSat)
  );

  assign periodNext = periodApply ? periodSat : periodO;

  // Simultaneous INC and DEC edges cancel.
  assign powerApply = incEdge ^ decEdge;

  m3_sat_addsub #(.W(POWER_W)) uPowerSat (
    .valueI  (power),
    .deltaI  (PW_STEP),
    .subI    (decEdge),
    .minI    ('0),
    .maxI    (PW_MAX),
    .resultO (powerSat)
  );

  assign powerNext = powerApply ? powerSat : power;

  always_comb begin
    if (dirO == 1'b0) begin
      stepNext = (stepO == STEP_LAST) ? '0 : (stepO + STEP_ONE);
    end else begin
      stepNext = (stepO == '0) ? STEP_LAST : (stepO - STEP_ONE);
    end
  end

  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) begin
      state    <= IDLE;
      stepO    <= STEP_LAST;
      stepStbO <= 1'b0;
      periodO  <= P_MAX;
      remain   <= P_MAX;
      power    <= PW_INIT;
      powerO   <= '0;
      dirO     <= 1'b0;
      runningO <= 1'b0;
      incQ     <= 1'b0;
      decQ     <= 1'b0;
    end else begin
      incQ     <= m3powerINCi;
      decQ     <= m3powerDECi;
      stepStbO <= 1'b0;

      if (m3forceStopI) begin
        // Step, period and remain stay frozen until the operator drops start.
        state    <= FSTOP;
        powerO   <= '0;
        runningO <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (m3startI) begin
              state    <= RUN;
              runningO <= 1'b1;
              dirO     <= m3invRotateI;
              remain   <= periodO;
              power    <= PW_INIT;
              powerO   <= PW_INIT;
            end else begin
              periodO <= P_MAX;
              stepO   <= STEP_LAST;
              remain  <= P_MAX;
              powerO  <= '0;
            end
          end

          FSTOP: begin
            if (!m3startI) begin
              state    <= IDLE;
              runningO <= 1'b0;
              periodO  <= P_MAX;
              stepO    <= STEP_LAST;
              remain   <= P_MAX;
              powerO   <= '0;
            end
          end

          RUN, REVERSE: begin
            if (!m3startI) begin
              state    <= IDLE;
              runningO <= 1'b0;
              periodO  <= P_MAX;
              stepO    <= STEP_LAST;
              remain   <= P_MAX;
              powerO   <= '0;
            end else begin
              power  <= powerNext;
              powerO <= powerNext;

              if (boundary) begin
                stepStbO <= 1'b1;
                stepO    <= stepNext;
                periodO  <= periodNext;
                remain   <= periodNext;
              end else begin
                remain <= remain - P_ONE;
              end

              if (state == RUN) begin
                if (m3invRotateI != dirO) begin
                  state <= REVERSE;
                end
              end else begin
                // Direction flips only once fully decelerated; a cancelled
                // request returns to RUN with the original direction.
                if (boundary && (periodO == P_MAX)) begin
                  state <= RUN;
                  dirO  <= ~dirO;
                end else if (m3invRotateI == dirO) begin
                  state <= RUN;
                end
              end
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
